// File: rtl/merge_pkg.sv
// Shared source identifiers for the demux/merge datapath.
// The encoding matches the demux select: 0 = stream A, 1 = stream B.
package merge_pkg;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: bit 0 of req/gnt is stream A and bit 1 is stream B.
// On a tie, the grant goes to the requester that was not served last.
module rr_arb2
    import merge_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_src;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_src == SRC_B) ? 2'b01 : 2'b10;
        end
    end

    // last_src resets to B so that A wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_src <= SRC_B;
        end else if (advance) begin
            last_src <= gnt[1] ? SRC_B : SRC_A;
        end
    end

endmodule

// File: rtl/merge2to1_4bit_rr.sv
// Round-robin 2:1 stream merge with a registered output and a source tag.
// Define MERGE_COUNT_EN to add per-input handshake counters (a_count/b_count).
module merge2to1_4bit_rr
   import merge_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic [WIDTH-1:0] y_data,
   output logic             y_src,
   output logic             y_valid,
   input  logic             y_ready
`ifdef MERGE_COUNT_EN
   ,
   output logic [CNT_W-1:0] a_count,
   output logic [CNT_W-1:0] b_count
`endif
);

   logic       load;
   logic       advance;
   logic [1:0] req;
   logic [1:0] gnt;

   assign load    = !y_valid || y_ready;
   assign req     = {b_valid, a_valid};
   assign advance = load && (|req);

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .advance (advance),
      .gnt     (gnt)
   );

   // Readies are held low during reset so no word is accepted and then discarded.
   assign a_ready = rst_n && load && gnt[0];
   assign b_ready = rst_n && load && gnt[1];

   // Output register: loads the granted word when free, holds it while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_valid <= 1'b0;
         y_data  <= '0;
         y_src   <= SRC_A;
      end else if (load) begin
         if (|gnt) begin
            y_valid <= 1'b1;
            y_data  <= gnt[1] ? b_data : a_data;
            y_src   <= gnt[1] ? SRC_B : SRC_A;
         end else begin
            y_valid <= 1'b0;
         end
      end
   end

`ifdef MERGE_COUNT_EN
   // Per-input handshake counters, wrapping naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_count <= '0;
         b_count <= '0;
      end else begin
         if (a_valid && a_ready) begin
            a_count <= a_count + CNT_W'(1);
         end
         if (b_valid && b_ready) begin
            b_count <= b_count + CNT_W'(1);
         end
      end
   end
`endif

endmodule
